extio_access_sched: RTL and testbench

- Arbitrates the two crossbar masters (NrSlaves = 2) for the ExtIO region (0x4000_0000..0x4FFF_FFFF). Decodes each access to one of seven peripherals, sequences one outstanding access at a time, and returns data or a decode/timeout error.
- Sits behind the ExtIO crossbar port, in front of BOOT, UART, SPI, Ethernet, GPIO, HID and Mouse.

---
 rtl/extio_access_sched_if.sv | 45 ++++
 rtl/extio_access_sched.sv | 164 ++++++++++++++++
 tb/tb_extio_access_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/extio_access_sched_if.sv
// Bus bundle for the ExtIO access scheduler: requester side, response side and
// the seven-peripheral access port. The scheduler uses the slave modport.
interface extio_access_sched_if #(
  parameter int NrMasters = 2,
  parameter int NrPeriph  = 7
);
  logic [NrMasters-1:0]    req_valid_i;
  logic [NrMasters-1:0]    req_ready_o;
  logic [NrMasters*64-1:0] req_addr_i;
  logic [NrMasters-1:0]    req_we_i;
  logic [NrMasters*64-1:0] req_wdata_i;
  logic [NrMasters*8-1:0]  req_be_i;

  logic [NrMasters-1:0]    rsp_valid_o;
  logic [63:0]             rsp_rdata_o;
  logic                    rsp_err_o;

  logic [NrPeriph-1:0]     per_sel_o;
  logic [63:0]             per_addr_o;
  logic                    per_we_o;
  logic [63:0]             per_wdata_o;
  logic [7:0]              per_be_o;
  logic [NrPeriph-1:0]     per_ack_i;
  logic [NrPeriph*64-1:0]  per_rdata_i;

  logic                    busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output per_sel_o, per_addr_o, per_we_o, per_wdata_o, per_be_o,
    input  per_ack_i, per_rdata_i,
    output busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  per_sel_o, per_addr_o, per_we_o, per_wdata_o, per_be_o,
    output per_ack_i, per_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/extio_access_sched.sv
// ExtIO access scheduler: round-robin grant, address decode to seven peripherals,
// one outstanding access. Optional ack timeout enabled by macro EXTIO_TIMEOUT_EN.
module extio_access_sched #(
  parameter int NrMasters     = 2,
  parameter int NrPeriph      = 7,
  parameter int TimeoutCycles = 255
) (
  input logic                 clk_i,
  input logic                 rst_i,
  extio_access_sched_if.slave bus
);
  localparam int MW     = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam int HidIdx = 5;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [MW-1:0]       r_rrPtr;
  logic [MW-1:0]       r_owner;
  logic [63:0]         r_addr;
  logic                r_we;
  logic [63:0]         r_wdata;
  logic [7:0]          r_be;
  logic [NrPeriph-1:0] r_sel;
  logic [63:0]         r_rspData;
  logic                r_rspErr;

  logic [MW-1:0]       w_winner;
  logic                w_anyReq;
  logic                w_grant;
  logic [63:0]         w_winAddr;
  logic [3:0]          w_idx;
  logic                w_offOk;
  logic                w_hit;
  logic [NrPeriph-1:0] w_decSel;
  logic                w_ack;
  logic [63:0]         w_selRdata;
  logic                w_timeout;

  // Scan from the pointer downwards so the highest-priority requester is written last.
  always_comb begin
    w_winner = '0;
    w_anyReq = 1'b0;
    for (int k = NrMasters - 1; k >= 0; k--) begin
      if (bus.req_valid_i[(int'(r_rrPtr) + k) % NrMasters]) begin
        w_winner = MW'((int'(r_rrPtr) + k) % NrMasters);
        w_anyReq = 1'b1;
      end
    end
  end

  assign w_grant   = (r_state == IDLE) && w_anyReq && !rst_i;
  assign w_winAddr = bus.req_addr_i[int'(w_winner)*64 +: 64];
  assign w_idx     = w_winAddr[27:24];
  assign w_offOk   = (w_idx == 4'(HidIdx)) ? (w_winAddr[23:20] == 4'h0)
                                           : (w_winAddr[23:16] == 8'h00);
  assign w_hit     = (w_winAddr[63:28] == 36'h4) && (int'(w_idx) < NrPeriph) && w_offOk;

  always_comb begin
    w_decSel = '0;
    for (int p = 0; p < NrPeriph; p++) begin
      w_decSel[p] = w_hit && (w_idx == 4'(p));
    end
  end

  always_comb begin
    w_selRdata = '0;
    for (int p = 0; p < NrPeriph; p++) begin
      if (r_sel[p]) begin
        w_selRdata = w_selRdata | bus.per_rdata_i[p*64 +: 64];
      end
    end
  end

  assign w_ack = (r_state == ACCESS) && |(bus.per_ack_i & r_sel);

`ifdef EXTIO_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_toCnt;

  // Counter holds the number of completed ACCESS cycles without ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_toCnt <= '0;
    end else if (w_grant) begin
      r_toCnt <= '0;
    end else if ((r_state == ACCESS) && !w_ack) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ACCESS) && (r_toCnt == CntW'(TimeoutCycles - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_nextState = w_hit ? ACCESS : RESP;
      ACCESS:  if (w_ack || w_timeout) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A decode miss preloads the error response so RESP follows directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rrPtr   <= '0;
      r_owner   <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_sel     <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else if (w_grant) begin
      r_rrPtr   <= MW'((int'(w_winner) + 1) % NrMasters);
      r_owner   <= w_winner;
      r_addr    <= w_winAddr;
      r_we      <= bus.req_we_i[w_winner];
      r_wdata   <= bus.req_wdata_i[int'(w_winner)*64 +: 64];
      r_be      <= bus.req_be_i[int'(w_winner)*8 +: 8];
      r_sel     <= w_decSel;
      r_rspData <= '0;
      r_rspErr  <= !w_hit;
    end else if (w_ack) begin
      r_rspData <= r_we ? 64'h0 : w_selRdata;
      r_rspErr  <= 1'b0;
    end else if (w_timeout) begin
      r_rspData <= '0;
      r_rspErr  <= 1'b1;
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    for (int m = 0; m < NrMasters; m++) begin
      bus.req_ready_o[m] = w_grant && (int'(w_winner) == m);
      bus.rsp_valid_o[m] = (r_state == RESP) && (int'(r_owner) == m);
    end
    bus.rsp_rdata_o = (r_state == RESP) ? r_rspData : 64'h0;
    bus.rsp_err_o   = (r_state == RESP) && r_rspErr;
    bus.per_sel_o   = (r_state == ACCESS) ? r_sel : '0;
    bus.per_addr_o  = r_addr;
    bus.per_we_o    = r_we;
    bus.per_wdata_o = r_wdata;
    bus.per_be_o    = r_be;
    bus.busy_o      = (r_state != IDLE);
  end
endmodule

// File: tb/tb_extio_access_sched.sv
// Directed bench for extio_access_sched: vector table of single accesses plus
// sequences for timeout, reset-in-flight and two-master alternation.
module tb_extio_access_sched;
  localparam int NrMasters = 2;
  localparam int NrPeriph  = 7;
  localparam int TbTimeout = 4;
`ifdef EXTIO_TIMEOUT_EN
  localparam int WrDelay = 3;
`else
  localparam int WrDelay = 4;
`endif

  typedef struct {
    int          master;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          ackDelay;
    logic [63:0] perRdata;
    logic        hit;
    logic [6:0]  expSel;
    logic [63:0] expRdata;
    logic        expErr;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  logic [NrPeriph-1:0]    ackDrv     = '0;
  logic [NrPeriph-1:0]    autoAckVec = '0;
  logic                   autoAck    = 1'b0;
  logic [NrPeriph*64-1:0] rdataDrv   = '0;

  extio_access_sched_if #(.NrMasters(NrMasters), .NrPeriph(NrPeriph)) bus ();

  extio_access_sched #(
    .NrMasters(NrMasters), .NrPeriph(NrPeriph), .TimeoutCycles(TbTimeout)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  assign bus.per_ack_i   = ackDrv | autoAckVec;
  assign bus.per_rdata_i = rdataDrv;

  always #5 clk_i = ~clk_i;

  // Immediate-ack peripheral used by the alternation sequence.
  always @(negedge clk_i) autoAckVec <= autoAck ? bus.per_sel_o : '0;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic driveReq(input int m, input logic [63:0] addr, input logic we,
                          input logic [63:0] wdata, input logic [7:0] be);
    bus.req_valid_i[m]          = 1'b1;
    bus.req_addr_i[m*64 +: 64]  = addr;
    bus.req_we_i[m]             = we;
    bus.req_wdata_i[m*64 +: 64] = wdata;
    bus.req_be_i[m*8 +: 8]      = be;
  endtask

  task automatic applyStimulus(input vec_t v);
    int idx = 0;
    for (int p = 0; p < NrPeriph; p++) if (v.expSel[p]) idx = p;
    @(posedge clk_i); #1;
    bus.req_valid_i = '0;
    driveReq(v.master, v.addr, v.we, v.wdata, v.be);
    @(negedge clk_i);
    checkOutput("grant", 64'(bus.req_ready_o), 64'(2'b01 << v.master));
    @(posedge clk_i); #1;
    bus.req_valid_i = '0;
    if (v.hit) begin
      for (int c = 0; c <= v.ackDelay; c++) begin
        if (c == v.ackDelay) begin
          ackDrv = v.expSel;
          rdataDrv[idx*64 +: 64] = v.perRdata;
        end else begin
          ackDrv = ~v.expSel;
        end
        @(negedge clk_i);
        checkOutput("per_sel", 64'(bus.per_sel_o), 64'(v.expSel));
        checkOutput("per_addr", bus.per_addr_o, v.addr);
        checkOutput("per_we", 64'(bus.per_we_o), 64'(v.we));
        checkOutput("per_wdata", bus.per_wdata_o, v.wdata);
        checkOutput("per_be", 64'(bus.per_be_o), 64'(v.be));
        checkOutput("rsp_idle", 64'(bus.rsp_valid_o), 64'h0);
        @(posedge clk_i); #1;
        ackDrv = '0;
      end
    end
    @(negedge clk_i);
    checkOutput("rsp_valid", 64'(bus.rsp_valid_o), 64'(2'b01 << v.master));
    checkOutput("rsp_rdata", bus.rsp_rdata_o, v.expRdata);
    checkOutput("rsp_err", 64'(bus.rsp_err_o), 64'(v.expErr));
    checkOutput("sel_in_resp", 64'(bus.per_sel_o), 64'h0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 64'h4100_0008, 1'b0, 64'h0,    8'hFF, 0,       64'hDEAD_BEEF,          1'b1, 7'b0000010, 64'hDEAD_BEEF,          1'b0};
    vecs[1] = '{1, 64'h4701_0000, 1'b0, 64'h0,    8'hFF, 0,       64'h0,                  1'b0, 7'b0000000, 64'h0,                  1'b1};
    vecs[2] = '{0, 64'h4101_0000, 1'b0, 64'h0,    8'hFF, 0,       64'h0,                  1'b0, 7'b0000000, 64'h0,                  1'b1};
    vecs[3] = '{1, 64'h450F_FFF8, 1'b0, 64'h0,    8'hFF, 1,       64'hCAFE_F00D_1122_3344, 1'b1, 7'b0100000, 64'hCAFE_F00D_1122_3344, 1'b0};
    vecs[4] = '{0, 64'h4300_0010, 1'b1, 64'h1234, 8'h0F, WrDelay, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'b0001000, 64'h0,                  1'b0};
    vecs[5] = '{1, 64'h4000_0100, 1'b0, 64'h0,    8'hF0, 2,       64'h0123_4567_89AB_CDEF, 1'b1, 7'b0000001, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[6] = '{0, 64'h5400_0000, 1'b0, 64'h0,    8'hFF, 0,       64'h0,                  1'b0, 7'b0000000, 64'h0,                  1'b1};
    vecs[7] = '{1, 64'h4610_0000, 1'b0, 64'h0,    8'hFF, 0,       64'h0,                  1'b0, 7'b0000000, 64'h0,                  1'b1};
    vecs[8] = '{0, 64'h4600_FFF8, 1'b0, 64'h0,    8'h01, 0,       64'h0000_0000_0000_00A5, 1'b1, 7'b1000000, 64'h0000_0000_0000_00A5, 1'b0};
    vecs[9] = '{1, 64'h4510_0000, 1'b0, 64'h0,    8'hFF, 0,       64'h0,                  1'b0, 7'b0000000, 64'h0,                  1'b1};

    rst_i           = 1'b1;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_we_i    = '0;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '0;
    #2;
    checkOutput("reset_ready", 64'(bus.req_ready_o), 64'h0);
    checkOutput("reset_sel", 64'(bus.per_sel_o), 64'h0);
    checkOutput("reset_rsp", 64'(bus.rsp_valid_o), 64'h0);
    checkOutput("reset_busy", 64'(bus.busy_o), 64'h0);
    checkOutput("reset_addr", bus.per_addr_o, 64'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

`ifdef EXTIO_TIMEOUT_EN
    // No ack: select held TbTimeout cycles, then error response.
    @(posedge clk_i); #1;
    driveReq(0, 64'h4100_0008, 1'b0, 64'h0, 8'hFF);
    @(negedge clk_i);
    checkOutput("to_grant", 64'(bus.req_ready_o), 64'h1);
    @(posedge clk_i); #1;
    bus.req_valid_i = '0;
    for (int c = 0; c < TbTimeout; c++) begin
      @(negedge clk_i);
      checkOutput("to_sel_held", 64'(bus.per_sel_o), 64'h02);
    end
    @(negedge clk_i);
    checkOutput("to_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    checkOutput("to_rsp_err", 64'(bus.rsp_err_o), 64'h1);
    checkOutput("to_rsp_rdata", bus.rsp_rdata_o, 64'h0);
    checkOutput("to_sel_drop", 64'(bus.per_sel_o), 64'h0);
    begin
      vec_t late;
      late = '{0, 64'h4100_0008, 1'b0, 64'h0, 8'hFF, TbTimeout - 1, 64'h55, 1'b1, 7'b0000010, 64'h55, 1'b0};
      applyStimulus(late);
    end
`endif

    // Reset in the middle of an access: everything drops, no response.
    @(posedge clk_i); #1;
    driveReq(0, 64'h4100_0008, 1'b0, 64'h0, 8'hFF);
    @(posedge clk_i); #1;
    bus.req_valid_i = '0;
    @(negedge clk_i);
    checkOutput("pre_rst_sel", 64'(bus.per_sel_o), 64'h02);
    #1;
    rst_i           = 1'b1;
    bus.req_valid_i = 2'b11;
    #1;
    checkOutput("rst_sel", 64'(bus.per_sel_o), 64'h0);
    checkOutput("rst_busy", 64'(bus.busy_o), 64'h0);
    checkOutput("rst_ready", 64'(bus.req_ready_o), 64'h0);
    checkOutput("rst_rsp", 64'(bus.rsp_valid_o), 64'h0);
    checkOutput("rst_addr", bus.per_addr_o, 64'h0);
    repeat (2) begin
      @(negedge clk_i);
      checkOutput("rst_no_rsp", 64'(bus.rsp_valid_o), 64'h0);
    end
    bus.req_valid_i = '0;
    rst_i           = 1'b0;

    // Both masters request continuously with immediate acks: M0 first, then alternate.
    rdataDrv[4*64 +: 64] = 64'h4;
    rdataDrv[2*64 +: 64] = 64'h2;
    autoAck = 1'b1;
    @(posedge clk_i); #1;
    driveReq(0, 64'h4400_0000, 1'b0, 64'h0, 8'hFF);
    driveReq(1, 64'h4200_0000, 1'b0, 64'h0, 8'hFF);
    for (int c = 0; c < 12; c++) begin
      int m;
      m = (c / 3) % 2;
      @(negedge clk_i);
      case (c % 3)
        0: begin
          checkOutput("alt_grant", 64'(bus.req_ready_o), (m == 1) ? 64'h2 : 64'h1);
          checkOutput("alt_sel0", 64'(bus.per_sel_o), 64'h0);
        end
        1: begin
          checkOutput("alt_ready1", 64'(bus.req_ready_o), 64'h0);
          checkOutput("alt_sel", 64'(bus.per_sel_o), (m == 1) ? 64'h04 : 64'h10);
        end
        default: begin
          checkOutput("alt_ready2", 64'(bus.req_ready_o), 64'h0);
          checkOutput("alt_rsp", 64'(bus.rsp_valid_o), (m == 1) ? 64'h2 : 64'h1);
          checkOutput("alt_rdata", bus.rsp_rdata_o, (m == 1) ? 64'h2 : 64'h4);
          checkOutput("alt_err", 64'(bus.rsp_err_o), 64'h0);
        end
      endcase
    end
    bus.req_valid_i = '0;
    autoAck = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
